// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- fetch program-counter generator
//
// Produces the instruction-fetch address and a valid/ready fetch request.
// A three-state FSM (BOOT -> RUN, RUN -> HALT) sequences the block:
//   BOOT : one cycle after reset release, no request issued.
//   RUN  : issues sequential fetches, follows redirects and traps.
//   HALT : entered when a trap/redirect target is not 4-byte aligned;
//          only reset leaves it.
//
// Handshake: fetch_valid_o/fetch_ready_i follow strict valid/ready rules.
// Once fetch_valid_o is high it stays high, and pc_o stays stable, until
// the cycle fetch_ready_i is high; the fetch is accepted on that rising
// edge. Valid never depends on ready.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   stall_i              hazard hold: no new request is started
//   redirect_valid_i     branch/jump taken, target in redirect_target_i
//   trap_valid_i         trap taken, handler address in trap_vector_i
//   fetch_valid_o        fetch request valid
//   fetch_ready_i        instruction memory accepts the request
//   pc_o                 current fetch address (bytes)
//   pc_plus_step_o       pc_o + STEP, wraps modulo 2^XLEN
//   halted_o             high while in HALT
//   dbg_state            FSM state (0 BOOT, 1 RUN, 2 HALT) for observation
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              STEP         = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vector_i,
    output logic            fetch_valid_o,
    input  logic            fetch_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_step_o,
    output logic            halted_o,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            out_q, out_d;          // request shown but not yet accepted
    logic            pend_v_q, pend_v_d;
    logic            pend_trap_q, pend_trap_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;

    // Winning control-flow change once this cycle's inputs are merged with
    // the pending entry. A live trap beats everything, a pending trap beats
    // a live redirect, and a live redirect replaces a pending redirect.
    logic            sel_v;
    logic            sel_trap;
    logic [XLEN-1:0] sel_tgt;

    assign pc_o           = pc_q;
    assign pc_plus_step_o = pc_q + XLEN'(STEP);
    assign halted_o       = (state_q == HALT);
    assign dbg_state      = state_q;

    always_comb begin
        sel_v    = 1'b0;
        sel_trap = 1'b0;
        sel_tgt  = pend_tgt_q;
        if (trap_valid_i) begin
            sel_v    = 1'b1;
            sel_trap = 1'b1;
            sel_tgt  = trap_vector_i;
        end else if (pend_v_q && pend_trap_q) begin
            sel_v    = 1'b1;
            sel_trap = 1'b1;
            sel_tgt  = pend_tgt_q;
        end else if (redirect_valid_i) begin
            sel_v    = 1'b1;
            sel_trap = 1'b0;
            sel_tgt  = redirect_target_i;
        end else if (pend_v_q) begin
            sel_v    = 1'b1;
            sel_trap = 1'b0;
            sel_tgt  = pend_tgt_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        out_d         = out_q;
        pend_v_d      = pend_v_q;
        pend_trap_d   = pend_trap_q;
        pend_tgt_d    = pend_tgt_q;
        fetch_valid_o = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end

            RUN: begin
                fetch_valid_o = !stall_i || out_q;
                if (fetch_valid_o && !fetch_ready_i) begin
                    // Request stalls at memory: pc_o must not move, so any
                    // control-flow change is parked in the pending slot.
                    out_d       = 1'b1;
                    pend_v_d    = sel_v;
                    pend_trap_d = sel_trap;
                    pend_tgt_d  = sel_tgt;
                end else begin
                    // Either the request is accepted now or none is shown;
                    // in both cases pc_o is free to change at this edge.
                    out_d = 1'b0;
                    if (sel_v) begin
                        pend_v_d = 1'b0;
                        if (sel_tgt[1:0] != 2'b00) begin
                            state_d = HALT;
                        end else begin
                            pc_d = sel_tgt;
                        end
                    end else if (fetch_valid_o) begin
                        pc_d = pc_plus_step_o;
                    end
                end
            end

            HALT: begin
                state_d = HALT;
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VECTOR;
            out_q       <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_trap_q <= 1'b0;
            pend_tgt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_q       <= out_d;
            pend_v_q    <= pend_v_d;
            pend_trap_q <= pend_trap_d;
            pend_tgt_q  <= pend_tgt_d;
        end
    end

endmodule
